handshake_const_arbiter: RTL and testbench
==========================================

# handshake_const_arbiter

Shares one constant-producing output channel among `N_IN` dataless control-token requesters. Each accepted token selects a per-requester constant from a parameter table and emits it with the winning index. Selection is round-robin, one token per cycle. The block sits between several control paths of the elastic datapath and a single consumer, replacing `N_IN` separate constant sources plus a merge. The output is registered (one-entry opaque buffer) to break the valid/ready combinational path from consumer to requesters.

## Interface
Parameters:
- `N_IN`, default 4: number of requester channels; legal range 2..16.
- `DATA_WIDTH`, default 32: width of each constant and of `outs`.
- `CONST_TABLE`, default {32'd4, 32'd3, 32'd2, 32'd1}: `N_IN*DATA_WIDTH` bits; entry i occupies `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `IDX_W`, localparam = max(1, clog2(N_IN)).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-low reset.
- `ctrl_valid` in N_IN: token offered by requester i.
- `ctrl_ready` out N_IN: token i accepted this cycle.
- `outs` out DATA_WIDTH: registered constant.
- `outs_idx` out IDX_W: index of the requester that produced `outs`.
- `outs_valid` out 1: output register full.
- `outs_ready` in 1: consumer accepts.

## Operation
- State: `full` (drives `outs_valid`), data register `outs`, index register `outs_idx`, round-robin pointer `ptr` (IDX_W bits).
- `load_en = !full || outs_ready`.
- Grant `g` = first i with `ctrl_valid[i]`, scanning circularly from `ptr` (ptr, ptr+1, …, N_IN-1, 0, …, ptr-1). `any = |ctrl_valid`.
- `ctrl_ready[i] = load_en && any && (i == g)`. At most one bit is set. The signal is combinational from `ctrl_valid`, `outs_ready` and state.
- On a clock edge with `load_en && any`: `outs <= CONST_TABLE[g]`, `outs_idx <= g`, `full <= 1`, `ptr <= (g == N_IN-1) ? 0 : g+1`.
- On a clock edge with `load_en && !any`: `full <= 0`. `outs`, `outs_idx` and `ptr` hold.
- With `!load_en`, all state holds. `outs` and `outs_idx` stay stable while `outs_valid && !outs_ready`.
- The pointer advances only on an accepted token, never on idle cycles.
- Simultaneous output drain and new grant in one cycle is a normal case and gives back-to-back throughput.

## Timing
- Reset (`rst == 0` at an edge): `full = 0`, `outs = 0`, `outs_idx = 0`, `ptr = 0`. After that edge, `ctrl_ready = 0` only while `rst` is held low. Reset asserted mid-transfer discards any buffered token without handshake.
- Latency: a token accepted at edge k appears on `outs` with `outs_valid = 1` in cycle k+1.
- Throughput: 1 token/cycle while `outs_ready` stays high.
- Backpressure: with `full && !outs_ready`, all `ctrl_ready = 0` and `ptr` holds.
- Fairness: with all requesters continuously valid and output always ready, the grant order is 0,1,…,N_IN-1,0,… A continuously valid requester waits at most N_IN-1 grants.
- Wrap: a grant at N_IN-1 sets `ptr = 0`. For non-power-of-2 `N_IN`, `ptr` never takes values ≥ N_IN.
- No combinational path from `outs_ready` to `outs_valid`.

## Structure
- Shared package `handshake_pkg`: `clog2` function and a `HS_IDX_W(n)` helper. The constant table stays a module parameter.
- One sub-module, `rr_priority_pick`: combinational circular first-one finder.
  - Inputs: `req[N]`, `ptr`.
  - Outputs: `gnt_idx`, `any`.
  - Implemented as a double-width masked priority scan, so it can be reused by later merge/mux arbiters.
- The top level holds the registers, `load_en`, pointer update and table indexing. Target size is 150–250 lines total.

## Test plan
- Reset, then hold `ctrl_valid = 0000` with `outs_ready = 1` for 5 cycles → `outs_valid = 0`, `outs = 0`, `outs_idx = 0`, `ctrl_ready = 0000` throughout.
- Single request: pulse `ctrl_valid = 0100` for one cycle with `outs_ready = 1` → `ctrl_ready = 0100` that cycle. Next cycle `outs = 3`, `outs_idx = 2`, `outs_valid = 1`; the cycle after that `outs_valid = 0`.
- All requesters valid, `outs_ready = 1`, 8 cycles → `outs_idx` sequence 0,1,2,3,0,1,2,3 and `outs` sequence 1,2,3,4,1,2,3,4, one per cycle with no bubbles.
- Backpressure: with output full (`outs_idx = 1`), hold `outs_ready = 0` for 3 cycles with `ctrl_valid = 1111` → `ctrl_ready = 0000`, `outs = 2` and `outs_idx = 1` stable. Release → next grant is idx 2.
- Skip and wrap: `ptr = 3`, `ctrl_valid = 0011` → grant 0, then 1, then 0. `ptr` goes 3→1→2→1.
- Mid-operation reset: drive `rst = 0` for one edge while `outs_valid = 1`, `ptr = 2` → `outs_valid = 0`, `ptr = 0`. Next grant with `ctrl_valid = 1111` is idx 0.

Source files
------------

// File: rtl/handshake_pkg.sv
// Shared helpers for the elastic handshake blocks.
// Holds the ceil-log2 and index-width functions used to size arbiter index ports.
package handshake_pkg;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

  // A single requester still needs a one-bit index port.
  function automatic int HS_IDX_W(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Circular first-one finder: lowest set req bit at or after ptr, wrapping to 0.
// Scans a doubled request vector with the bits below ptr masked off.
module rr_priority_pick
  import handshake_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = HS_IDX_W(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any
);

  logic [2*N-1:0] doubled;
  logic [2*N-1:0] masked;

  // The upper copy is never masked, so a set request is always found within N positions of ptr.
  always_comb begin
    doubled = {req, req};
    masked  = '0;
    for (int j = 0; j < 2*N; j++) begin
      masked[j] = doubled[j] && (j >= int'(ptr));
    end
    gnt_idx = '0;
    for (int j = 2*N - 1; j >= 0; j--) begin
      if (masked[j]) begin
        gnt_idx = (j >= N) ? IDX_W'(j - N) : IDX_W'(j);
      end
    end
    any = |req;
  end

endmodule

// File: rtl/handshake_const_arbiter.sv
// Round-robin merge of dataless control tokens into one registered constant channel.
// Each accepted token emits its requester's table constant together with the requester index.
module handshake_const_arbiter
  import handshake_pkg::*;
#(
  parameter int                         N_IN        = 4,
  parameter int                         DATA_WIDTH  = 32,
  parameter logic [N_IN*DATA_WIDTH-1:0] CONST_TABLE = {32'd4, 32'd3, 32'd2, 32'd1},
  localparam int                        IDX_W       = HS_IDX_W(N_IN)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_IN-1:0]       ctrl_valid,
  output logic [N_IN-1:0]       ctrl_ready,
  output logic [DATA_WIDTH-1:0] outs,
  output logic [IDX_W-1:0]      outs_idx,
  output logic                  outs_valid,
  input  logic                  outs_ready
);

  logic             full;
  logic             load_en;
  logic             any;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] gnt;

  assign load_en    = !full || outs_ready;
  assign outs_valid = full;

  rr_priority_pick #(
    .N     (N_IN),
    .IDX_W (IDX_W)
  ) u_pick (
    .req     (ctrl_valid),
    .ptr     (ptr),
    .gnt_idx (gnt),
    .any     (any)
  );

  // No token is accepted while reset is held, so nothing can be lost across the reset edge.
  always_comb begin
    ctrl_ready = '0;
    if (rst && load_en && any) begin
      ctrl_ready[gnt] = 1'b1;
    end
  end

  // The pointer moves only on an accepted token; idle load cycles just drain the buffer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      full     <= 1'b0;
      outs     <= '0;
      outs_idx <= '0;
      ptr      <= '0;
    end else if (load_en) begin
      if (any) begin
        outs     <= CONST_TABLE[int'(gnt)*DATA_WIDTH +: DATA_WIDTH];
        outs_idx <= gnt;
        full     <= 1'b1;
        ptr      <= (gnt == IDX_W'(N_IN - 1)) ? '0 : gnt + 1'b1;
      end else begin
        full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_handshake_const_arbiter.sv
// Bench for handshake_const_arbiter: directed scenarios with literal expectations,
// then random traffic checked every cycle against a round-robin queue-free reference model.
module tb_handshake_const_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;

  logic          clk;
  logic          rst;
  logic [N-1:0]  ctrl_valid;
  logic [N-1:0]  ctrl_ready;
  logic [DW-1:0] outs;
  logic [1:0]    outs_idx;
  logic          outs_valid;
  logic          outs_ready;

  int vectors    = 0;
  int miscompares = 0;

  int tbl [N] = '{1, 2, 3, 4};

  handshake_const_arbiter #(
    .N_IN        (N),
    .DATA_WIDTH  (DW),
    .CONST_TABLE ({32'd4, 32'd3, 32'd2, 32'd1})
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ctrl_valid (ctrl_valid),
    .ctrl_ready (ctrl_ready),
    .outs       (outs),
    .outs_idx   (outs_idx),
    .outs_valid (outs_valid),
    .outs_ready (outs_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors = vectors + 1;
    if (actual !== expected) begin
      miscompares = miscompares + 1;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle's inputs just after the rising edge, then wait to the sampling edge.
  task automatic applyStimulus(input logic [N-1:0] v, input logic r, input logic rs);
    @(posedge clk);
    #1;
    ctrl_valid = v;
    outs_ready = r;
    rst        = rs;
    @(negedge clk);
  endtask

  // Reference model: architectural state described as plain integers.
  bit model_known = 0;
  bit m_full;
  int m_outs;
  int m_idx;
  int m_ptr;

  always @(negedge clk) begin
    int  g;
    bit  found;
    bit  load;
    logic [N-1:0] exp_ready;
    if (model_known) begin
      checkOutput("model outs_valid", 32'(outs_valid), 32'(m_full));
      checkOutput("model outs", outs, 32'(m_outs));
      checkOutput("model outs_idx", 32'(outs_idx), 32'(m_idx));
    end
    if (rst !== 1'b1) begin
      if (model_known) checkOutput("model ctrl_ready in reset", 32'(ctrl_ready), 32'd0);
      m_full = 0; m_outs = 0; m_idx = 0; m_ptr = 0;
      model_known = 1;
    end else if (model_known) begin
      load  = !m_full || outs_ready;
      found = 0;
      g     = 0;
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_ptr + k) % N;
        if (!found && ctrl_valid[i]) begin
          found = 1;
          g     = i;
        end
      end
      exp_ready = (load && found) ? N'(1 << g) : '0;
      checkOutput("model ctrl_ready", 32'(ctrl_ready), 32'(exp_ready));
      if (load && found) begin
        m_outs = tbl[g];
        m_idx  = g;
        m_full = 1;
        m_ptr  = (g + 1) % N;
      end else if (load) begin
        m_full = 0;
      end
    end
  end

  int exp_idx_seq [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  int exp_out_seq [8] = '{1, 2, 3, 4, 1, 2, 3, 4};

  initial begin
    rst        = 1'b0;
    ctrl_valid = '0;
    outs_ready = 1'b1;

    repeat (3) applyStimulus(4'b0000, 1'b1, 1'b0);

    // Idle after reset
    for (int c = 0; c < 5; c++) begin
      applyStimulus(4'b0000, 1'b1, 1'b1);
      checkOutput("idle outs_valid", 32'(outs_valid), 32'd0);
      checkOutput("idle outs", outs, 32'd0);
      checkOutput("idle outs_idx", 32'(outs_idx), 32'd0);
      checkOutput("idle ctrl_ready", 32'(ctrl_ready), 32'd0);
    end

    // Single request from requester 2
    applyStimulus(4'b0100, 1'b1, 1'b1);
    checkOutput("single ctrl_ready", 32'(ctrl_ready), 32'b0100);
    applyStimulus(4'b0000, 1'b1, 1'b1);
    checkOutput("single outs", outs, 32'd3);
    checkOutput("single outs_idx", 32'(outs_idx), 32'd2);
    checkOutput("single outs_valid", 32'(outs_valid), 32'd1);
    applyStimulus(4'b0000, 1'b1, 1'b1);
    checkOutput("single drained", 32'(outs_valid), 32'd0);

    // Re-home the pointer, then all requesters continuously valid
    applyStimulus(4'b0000, 1'b1, 1'b0);
    applyStimulus(4'b1111, 1'b1, 1'b1);
    checkOutput("rr first grant", 32'(ctrl_ready), 32'b0001);
    for (int c = 0; c < 8; c++) begin
      applyStimulus(4'b1111, 1'b1, 1'b1);
      checkOutput("rr outs_valid", 32'(outs_valid), 32'd1);
      checkOutput("rr outs_idx", 32'(outs_idx), 32'(exp_idx_seq[c]));
      checkOutput("rr outs", outs, 32'(exp_out_seq[c]));
    end

    // Backpressure with requester 1's constant buffered
    applyStimulus(4'b1111, 1'b1, 1'b1);
    checkOutput("bp pre outs_idx", 32'(outs_idx), 32'd0);
    for (int c = 0; c < 3; c++) begin
      applyStimulus(4'b1111, 1'b0, 1'b1);
      checkOutput("bp ctrl_ready", 32'(ctrl_ready), 32'd0);
      checkOutput("bp outs", outs, 32'd2);
      checkOutput("bp outs_idx", 32'(outs_idx), 32'd1);
      checkOutput("bp outs_valid", 32'(outs_valid), 32'd1);
    end
    applyStimulus(4'b1111, 1'b1, 1'b1);
    checkOutput("bp release grant", 32'(ctrl_ready), 32'b0100);
    applyStimulus(4'b0000, 1'b1, 1'b1);
    checkOutput("bp release outs", outs, 32'd3);

    // Skip and wrap from pointer 3 with only requesters 0 and 1 active
    applyStimulus(4'b0011, 1'b1, 1'b1);
    checkOutput("wrap grant a", 32'(ctrl_ready), 32'b0001);
    applyStimulus(4'b0011, 1'b1, 1'b1);
    checkOutput("wrap grant b", 32'(ctrl_ready), 32'b0010);
    applyStimulus(4'b0011, 1'b1, 1'b1);
    checkOutput("wrap grant c", 32'(ctrl_ready), 32'b0001);

    // Mid-operation reset with a token buffered and pointer at 2
    applyStimulus(4'b0010, 1'b1, 1'b1);
    checkOutput("pre-reset grant", 32'(ctrl_ready), 32'b0010);
    applyStimulus(4'b0000, 1'b0, 1'b0);
    checkOutput("pre-reset outs_valid", 32'(outs_valid), 32'd1);
    applyStimulus(4'b1111, 1'b1, 1'b1);
    checkOutput("post-reset outs_valid", 32'(outs_valid), 32'd0);
    checkOutput("post-reset grant", 32'(ctrl_ready), 32'b0001);

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      logic rs;
      logic [N-1:0] v;
      rs = ($urandom_range(63) != 0);
      v  = rs ? N'($urandom) : '0;
      applyStimulus(v, 1'($urandom_range(3) != 0), rs);
    end

    applyStimulus(4'b0000, 1'b1, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
